pipe_controller: RTL and testbench

PIPE_CONTROLLER -- requirements
Module: pipe_controller

---
 rtl/pipe_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_pipe_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// Decode/issue controller: turns one opcode per cycle into a registered EXE control bundle,
// owns the Z/N flag register and, when CTRL_MULT_SEQ_EN is defined, sequences multi-cycle MULTs.
//
// state     | meaning
// RUN       | accepting instructions when no hazard or flush is present
// MULT_BUSY | MULT occupies EXE; front end stalled, bubbles issued until the counter expires
module pipe_controller #(
    parameter int OP_W        = 6,
    parameter int WORD_W      = 32,
    parameter int CMD_W       = 4,
    parameter int MULT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [OP_W-1:0]   opCode,
    input  logic [WORD_W-1:0] src1,
    input  logic [WORD_W-1:0] src2,
    input  logic              hazard_detected,
    input  logic              flush,
    output logic [CMD_W-1:0]  EXE_CMD,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic              Is_Imm,
    output logic              ST_or_BNE,
    output logic              is_add_base,
    output logic              branchEn,
    output logic              jumpEnable,
    output logic [1:0]        Branch_command,
    output logic              branch_taken,
    output logic              Z,
    output logic              N,
    output logic              stall
);

    localparam logic [5:0] OP_ADD      = 6'd1;
    localparam logic [5:0] OP_SUB      = 6'd2;
    localparam logic [5:0] OP_AND      = 6'd3;
    localparam logic [5:0] OP_SLL      = 6'd4;
    localparam logic [5:0] OP_ADDI     = 6'd5;
    localparam logic [5:0] OP_LW       = 6'd6;
    localparam logic [5:0] OP_SW       = 6'd7;
    localparam logic [5:0] OP_CLR      = 6'd8;
    localparam logic [5:0] OP_MOVI     = 6'd9;
    localparam logic [5:0] OP_ADD_BASE = 6'd10;
    localparam logic [5:0] OP_BNE      = 6'd11;
    localparam logic [5:0] OP_JMP      = 6'd12;
    localparam logic [5:0] OP_CMP      = 6'd13;
    localparam logic [5:0] OP_MULT     = 6'd14;

    localparam logic [3:0] EXE_NO_OPERATION = 4'd0;
    localparam logic [3:0] EXE_ADD          = 4'd1;
    localparam logic [3:0] EXE_SUB          = 4'd2;
    localparam logic [3:0] EXE_AND          = 4'd3;
    localparam logic [3:0] EXE_SLL          = 4'd4;
    localparam logic [3:0] EXE_CLR          = 4'd5;
    localparam logic [3:0] EXE_MOVI         = 4'd6;
    localparam logic [3:0] EXE_MULT         = 4'd7;

    localparam logic [1:0] COND_BNE  = 2'd1;
    localparam logic [1:0] COND_JUMP = 2'd2;

    if (MULT_CYCLES < 2 || MULT_CYCLES > 16) begin : g_bad_mult_cycles
        $error("pipe_controller: MULT_CYCLES must be within 2..16");
    end

    logic             busy;
    logic             accept;
    logic             cmp_en;
    logic [CMD_W-1:0] exe_cmd_d;
    logic             wb_en_d, mem_r_en_d, mem_w_en_d, is_imm_d, st_or_bne_d, is_add_base_d;
    logic             branch_en_d, jump_en_d, branch_taken_d;
    logic [1:0]       branch_cmd_d;

    // flush outranks hazard; both only ever produce a bubble, so a single gate suffices
    assign accept = op_valid && !hazard_detected && !flush && !busy;

    always_comb begin
        exe_cmd_d      = CMD_W'(EXE_NO_OPERATION);
        wb_en_d        = 1'b0;
        mem_r_en_d     = 1'b0;
        mem_w_en_d     = 1'b0;
        is_imm_d       = 1'b0;
        st_or_bne_d    = 1'b0;
        is_add_base_d  = 1'b0;
        branch_en_d    = 1'b0;
        jump_en_d      = 1'b0;
        branch_cmd_d   = 2'b00;
        branch_taken_d = 1'b0;
        cmp_en         = 1'b0;
        if (accept) begin
            case (opCode)
                OP_W'(OP_ADD): begin exe_cmd_d = CMD_W'(EXE_ADD); wb_en_d = 1'b1; end
                OP_W'(OP_SUB): begin exe_cmd_d = CMD_W'(EXE_SUB); wb_en_d = 1'b1; end
                OP_W'(OP_AND): begin exe_cmd_d = CMD_W'(EXE_AND); wb_en_d = 1'b1; end
                OP_W'(OP_SLL): begin exe_cmd_d = CMD_W'(EXE_SLL); wb_en_d = 1'b1; end
                OP_W'(OP_ADDI): begin
                    exe_cmd_d = CMD_W'(EXE_ADD);
                    wb_en_d   = 1'b1;
                    is_imm_d  = 1'b1;
                end
                OP_W'(OP_LW), OP_W'(OP_ADD_BASE): begin
                    exe_cmd_d     = CMD_W'(EXE_ADD);
                    wb_en_d       = 1'b1;
                    is_imm_d      = 1'b1;
                    st_or_bne_d   = 1'b1;
                    mem_r_en_d    = 1'b1;
                    is_add_base_d = (opCode == OP_W'(OP_ADD_BASE));
                end
                OP_W'(OP_SW): begin
                    is_imm_d    = 1'b1;
                    st_or_bne_d = 1'b1;
                    mem_w_en_d  = 1'b1;
                end
                OP_W'(OP_CLR): begin
                    exe_cmd_d = CMD_W'(EXE_CLR);
                    wb_en_d   = 1'b1;
                    is_imm_d  = 1'b1;
                end
                OP_W'(OP_MOVI): begin
                    exe_cmd_d = CMD_W'(EXE_MOVI);
                    wb_en_d   = 1'b1;
                    is_imm_d  = 1'b1;
                end
                // resolved against the flag register as it stands before this edge
                OP_W'(OP_BNE): begin
                    is_imm_d       = 1'b1;
                    branch_en_d    = 1'b1;
                    branch_cmd_d   = COND_BNE;
                    branch_taken_d = ~Z;
                end
                OP_W'(OP_JMP): begin
                    is_imm_d       = 1'b1;
                    branch_en_d    = 1'b1;
                    jump_en_d      = 1'b1;
                    branch_cmd_d   = COND_JUMP;
                    branch_taken_d = 1'b1;
                end
                OP_W'(OP_CMP):  cmp_en = 1'b1;
                OP_W'(OP_MULT): exe_cmd_d = CMD_W'(EXE_MULT);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            EXE_CMD        <= CMD_W'(EXE_NO_OPERATION);
            WB_EN          <= 1'b0;
            MEM_R_EN       <= 1'b0;
            MEM_W_EN       <= 1'b0;
            Is_Imm         <= 1'b0;
            ST_or_BNE      <= 1'b0;
            is_add_base    <= 1'b0;
            branchEn       <= 1'b0;
            jumpEnable     <= 1'b0;
            Branch_command <= 2'b00;
            branch_taken   <= 1'b0;
            Z              <= 1'b0;
            N              <= 1'b0;
        end else begin
            EXE_CMD        <= exe_cmd_d;
            WB_EN          <= wb_en_d;
            MEM_R_EN       <= mem_r_en_d;
            MEM_W_EN       <= mem_w_en_d;
            Is_Imm         <= is_imm_d;
            ST_or_BNE      <= st_or_bne_d;
            is_add_base    <= is_add_base_d;
            branchEn       <= branch_en_d;
            jumpEnable     <= jump_en_d;
            Branch_command <= branch_cmd_d;
            branch_taken   <= branch_taken_d;
            if (cmp_en) begin
                Z <= (src1 == src2);
                N <= ($signed(src1) < $signed(src2));
            end
        end
    end

`ifdef CTRL_MULT_SEQ_EN
    localparam int         CNT_W     = $clog2(MULT_CYCLES);
    localparam logic [0:0] RUN       = 1'b0;
    localparam logic [0:0] MULT_BUSY = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] mult_cnt;
    logic             mult_start;

    assign mult_start = accept && (opCode == OP_W'(OP_MULT));
    assign busy       = (state == MULT_BUSY);
    assign stall      = busy;

    // counter holds the remaining busy cycles; leaving on 1 gives exactly MULT_CYCLES-1 stall cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            mult_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mult_start) begin
                        state    <= MULT_BUSY;
                        mult_cnt <= CNT_W'(MULT_CYCLES - 1);
                    end
                end
                MULT_BUSY: begin
                    if (flush) begin
                        state    <= RUN;
                        mult_cnt <= '0;
                    end else begin
                        mult_cnt <= mult_cnt - 1'b1;
                        if (mult_cnt == CNT_W'(1)) state <= RUN;
                    end
                end
                default: begin
                    state    <= RUN;
                    mult_cnt <= '0;
                end
            endcase
        end
    end
`else
    assign busy  = 1'b0;
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: decode table, flags/branches, bubble priority,
// MULT sequencing (either build) and asynchronous reset.
module tb_pipe_controller;

    localparam logic [5:0] OP_ADD      = 6'd1;
    localparam logic [5:0] OP_SUB      = 6'd2;
    localparam logic [5:0] OP_AND      = 6'd3;
    localparam logic [5:0] OP_SLL      = 6'd4;
    localparam logic [5:0] OP_ADDI     = 6'd5;
    localparam logic [5:0] OP_LW       = 6'd6;
    localparam logic [5:0] OP_SW       = 6'd7;
    localparam logic [5:0] OP_CLR      = 6'd8;
    localparam logic [5:0] OP_MOVI     = 6'd9;
    localparam logic [5:0] OP_ADD_BASE = 6'd10;
    localparam logic [5:0] OP_BNE      = 6'd11;
    localparam logic [5:0] OP_JMP      = 6'd12;
    localparam logic [5:0] OP_CMP      = 6'd13;
    localparam logic [5:0] OP_MULT     = 6'd14;
    localparam logic [5:0] OP_UNDEF    = 6'h3F;

    localparam logic [3:0] X_NOP  = 4'd0;
    localparam logic [3:0] X_ADD  = 4'd1;
    localparam logic [3:0] X_SUB  = 4'd2;
    localparam logic [3:0] X_AND  = 4'd3;
    localparam logic [3:0] X_SLL  = 4'd4;
    localparam logic [3:0] X_CLR  = 4'd5;
    localparam logic [3:0] X_MOVI = 4'd6;
    localparam logic [3:0] X_MULT = 4'd7;

    localparam logic [1:0] C_BNE = 2'd1;
    localparam logic [1:0] C_JMP = 2'd2;

    localparam logic [14:0] BUB = 15'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [5:0]  opCode = 6'd0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic        hazard_detected = 1'b0;
    logic        flush = 1'b0;

    logic [3:0]  EXE_CMD;
    logic        WB_EN, MEM_R_EN, MEM_W_EN, Is_Imm, ST_or_BNE, is_add_base;
    logic        branchEn, jumpEnable, branch_taken, Z, N, stall;
    logic [1:0]  Branch_command;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_controller dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .opCode(opCode),
        .src1(src1), .src2(src2), .hazard_detected(hazard_detected), .flush(flush),
        .EXE_CMD(EXE_CMD), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .Is_Imm(Is_Imm), .ST_or_BNE(ST_or_BNE), .is_add_base(is_add_base),
        .branchEn(branchEn), .jumpEnable(jumpEnable), .Branch_command(Branch_command),
        .branch_taken(branch_taken), .Z(Z), .N(N), .stall(stall)
    );

    wire [14:0] bundle = {EXE_CMD, WB_EN, MEM_R_EN, MEM_W_EN, Is_Imm, ST_or_BNE, is_add_base,
                          branchEn, jumpEnable, Branch_command, branch_taken};

    // cmd, wb, mem_r, mem_w, imm, st_or_bne, add_base, br_en, jmp_en, br_cmd, taken
    function automatic logic [14:0] mk(input logic [3:0] cmd, input logic wb, input logic mr,
                                       input logic mw, input logic imm, input logic sb,
                                       input logic ab, input logic be, input logic je,
                                       input logic [1:0] bc, input logic bt);
        return {cmd, wb, mr, mw, imm, sb, ab, be, je, bc, bt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic hz, input logic fl);
        op_valid = v; opCode = op; src1 = a; src2 = b; hazard_detected = hz; flush = fl;
    endtask

    task automatic issue(input string tag, input logic [5:0] op, input logic [14:0] exp);
        drive(1'b1, op, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        check(tag, 32'(bundle), 32'(exp));
        check({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    task automatic flags(input string tag, input logic ez, input logic en);
        check({tag, "_Z"}, 32'(Z), 32'(ez));
        check({tag, "_N"}, 32'(N), 32'(en));
    endtask

    initial begin
        // reset held across clock edges with a live instruction on the inputs
        drive(1'b1, OP_ADDI, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        step();
        check("rst_bundle", 32'(bundle), 32'(BUB));
        check("rst_stall", 32'(stall), 32'd0);
        flags("rst", 1'b0, 1'b0);

        rst = 1'b1;
        step();
        check("addi_first", 32'(bundle), 32'(mk(X_ADD, 1,0,0,1,0,0,0,0, 2'd0, 0)));

        issue("add",  OP_ADD,  mk(X_ADD,  1,0,0,0,0,0,0,0, 2'd0, 0));
        issue("sub",  OP_SUB,  mk(X_SUB,  1,0,0,0,0,0,0,0, 2'd0, 0));
        issue("and",  OP_AND,  mk(X_AND,  1,0,0,0,0,0,0,0, 2'd0, 0));
        issue("sll",  OP_SLL,  mk(X_SLL,  1,0,0,0,0,0,0,0, 2'd0, 0));
        issue("lw",   OP_LW,   mk(X_ADD,  1,1,0,1,1,0,0,0, 2'd0, 0));
        issue("sw",   OP_SW,   mk(X_NOP,  0,0,1,1,1,0,0,0, 2'd0, 0));
        issue("clr",  OP_CLR,  mk(X_CLR,  1,0,0,1,0,0,0,0, 2'd0, 0));
        issue("movi", OP_MOVI, mk(X_MOVI, 1,0,0,1,0,0,0,0, 2'd0, 0));
        issue("addb", OP_ADD_BASE, mk(X_ADD, 1,1,0,1,1,1,0,0, 2'd0, 0));
        issue("jmp",  OP_JMP,  mk(X_NOP,  0,0,0,1,0,0,1,1, C_JMP, 1));

        // flags and branch resolution
        drive(1'b1, OP_CMP, 32'd5, 32'd5, 1'b0, 1'b0);
        step();
        check("cmp_eq_bubble", 32'(bundle), 32'(BUB));
        flags("cmp_eq", 1'b1, 1'b0);
        issue("bne_not_taken", OP_BNE, mk(X_NOP, 0,0,0,1,0,0,1,0, C_BNE, 0));

        drive(1'b1, OP_CMP, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        step();
        flags("cmp_neg", 1'b0, 1'b1);
        issue("bne_taken", OP_BNE, mk(X_NOP, 0,0,0,1,0,0,1,0, C_BNE, 1));

        drive(1'b1, OP_CMP, 32'd5, 32'd5, 1'b1, 1'b0);
        step();
        check("cmp_hz_bubble", 32'(bundle), 32'(BUB));
        flags("cmp_hz", 1'b0, 1'b1);
        drive(1'b1, OP_CMP, 32'd5, 32'd5, 1'b0, 1'b1);
        step();
        flags("cmp_fl", 1'b0, 1'b1);
        drive(1'b0, OP_CMP, 32'd5, 32'd5, 1'b0, 1'b0);
        step();
        flags("cmp_inv", 1'b0, 1'b1);
        drive(1'b1, OP_CMP, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step();
        flags("cmp_pos", 1'b0, 1'b0);

        // bubble sources
        drive(1'b1, OP_LW, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        check("lw_hazard", 32'(bundle), 32'(BUB));
        drive(1'b1, OP_LW, 32'd0, 32'd0, 1'b1, 1'b1);
        step();
        check("lw_hz_flush", 32'(bundle), 32'(BUB));
        drive(1'b1, OP_LW, 32'd0, 32'd0, 1'b0, 1'b1);
        step();
        check("lw_flush", 32'(bundle), 32'(BUB));
        drive(1'b1, OP_UNDEF, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        check("undef_op", 32'(bundle), 32'(BUB));
        drive(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        check("not_valid", 32'(bundle), 32'(BUB));

        // MULT sequencing: ADD held on the inputs behind the MULT
        drive(1'b1, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        check("mult_cmd", 32'(bundle), 32'(mk(X_MULT, 0,0,0,0,0,0,0,0, 2'd0, 0)));
`ifdef CTRL_MULT_SEQ_EN
        check("mult_c0_stall", 32'(stall), 32'd1);
        drive(1'b1, OP_ADD, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        check("mult_c1_bub", 32'(bundle), 32'(BUB));
        check("mult_c1_stall", 32'(stall), 32'd1);
        hazard_detected = 1'b0;
        step();
        check("mult_c2_bub", 32'(bundle), 32'(BUB));
        check("mult_c2_stall", 32'(stall), 32'd1);
        step();
        check("mult_c3_bub", 32'(bundle), 32'(BUB));
        check("mult_c3_stall", 32'(stall), 32'd0);
        step();
        check("mult_add_issue", 32'(bundle), 32'(mk(X_ADD, 1,0,0,0,0,0,0,0, 2'd0, 0)));
        check("mult_add_stall", 32'(stall), 32'd0);

        drive(1'b1, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        check("fl_c0_stall", 32'(stall), 32'd1);
        drive(1'b1, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        check("fl_c1_stall", 32'(stall), 32'd1);
        flush = 1'b1;
        step();
        check("fl_after_stall", 32'(stall), 32'd0);
        check("fl_after_bub", 32'(bundle), 32'(BUB));
        flush = 1'b0;
        step();
        check("fl_add_issue", 32'(bundle), 32'(mk(X_ADD, 1,0,0,0,0,0,0,0, 2'd0, 0)));
`else
        check("mult_nostall", 32'(stall), 32'd0);
        drive(1'b1, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        check("mult_add_next", 32'(bundle), 32'(mk(X_ADD, 1,0,0,0,0,0,0,0, 2'd0, 0)));
        check("mult_add_stall", 32'(stall), 32'd0);
        drive(1'b1, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b1);
        step();
        check("fl_bub", 32'(bundle), 32'(BUB));
        check("fl_stall", 32'(stall), 32'd0);
`endif

        // asynchronous reset in the middle of a MULT, with Z set beforehand
        drive(1'b1, OP_CMP, 32'd9, 32'd9, 1'b0, 1'b0);
        step();
        flags("pre_rst", 1'b1, 1'b0);
        drive(1'b1, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
`ifdef CTRL_MULT_SEQ_EN
        check("mid_mult_stall", 32'(stall), 32'd1);
`else
        check("mid_mult_stall", 32'(stall), 32'd0);
`endif
        drive(1'b1, OP_ADD, 32'd0, 32'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_bundle", 32'(bundle), 32'(BUB));
        check("arst_stall", 32'(stall), 32'd0);
        flags("arst", 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        check("post_rst_add", 32'(bundle), 32'(mk(X_ADD, 1,0,0,0,0,0,0,0, 2'd0, 0)));
        check("post_rst_stall", 32'(stall), 32'd0);
        issue("post_rst_bne", OP_BNE, mk(X_NOP, 0,0,0,1,0,0,1,0, C_BNE, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
